bram_frame_streamer: RTL and testbench

- Next-generation pseudo-sensor source: reads a stored frame from a synchronous BRAM and emits it as a pixel stream with valid/ready backpressure.
- Adds runtime ROI crop, integer decimation, configurable BRAM read latency, multi-bit pixels, continuous (looping) mode and an output skid FIFO.
- Sits between the frame BRAM and the LeNet preprocessing front end (resize/normalize).

---
 rtl/bram_frame_streamer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_bram_frame_streamer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_frame_streamer.sv
// bram_frame_streamer: reads a rectangular, optionally decimated region of a stored frame
// from a synchronous BRAM and emits it as a valid/ready pixel stream with sof/eol/eof
// sideband. It can run one frame per start, or loop frames until stop is seen.
//
// Ports:
//   clk, srst             clock, synchronous active-high reset
//   start, stop, cont     frame start pulse, end-of-loop request, continuous-mode select
//   roi_x0, roi_y0        ROI top-left corner in stored-frame pixels
//   roi_w, roi_h, step    ROI output size (after decimation) and decimation factor (0 -> 1)
//   bram_addr, bram_en    BRAM read request
//   bram_dout             BRAM read data, RD_LAT clocks after bram_en
//   m_valid, m_ready      output handshake
//   m_data, m_sof/eol/eof output pixel and frame markers
//   busy                  high from start acceptance until the last pixel is handed off
//   frame_done            pulse on the clock an eof beat transfers
//   cfg_err               sticky flag for a rejected start
module bram_frame_streamer #(
  parameter int unsigned IN_W   = 640,
  parameter int unsigned IN_H   = 480,
  parameter int unsigned AB     = 19,
  parameter int unsigned PW     = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned FD     = 4
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          start,
  input  logic          stop,
  input  logic          cont,
  input  logic [15:0]   roi_x0,
  input  logic [15:0]   roi_y0,
  input  logic [15:0]   roi_w,
  input  logic [15:0]   roi_h,
  input  logic [3:0]    step,
  output logic [AB-1:0] bram_addr,
  output logic          bram_en,
  input  logic [PW-1:0] bram_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [PW-1:0] m_data,
  output logic          m_sof,
  output logic          m_eol,
  output logic          m_eof,
  output logic          busy,
  output logic          frame_done,
  output logic          cfg_err
);

  localparam int unsigned AW  = AB + 1;
  localparam int unsigned PTW = $clog2(FD);
  localparam int unsigned CW  = PTW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e state_q, state_d;

  // Latched frame configuration and issue counters
  logic [15:0]   w_q, w_d, h_q, h_d;
  logic [3:0]    step_q, step_d;
  logic [AW-1:0] row_inc_q, row_inc_d;
  logic [AB-1:0] addr_q, addr_d, row_base_q, row_base_d;
  logic [15:0]   rx_q, rx_d, ry_q, ry_d;
  logic          cont_q, cont_d, stop_seen_q, stop_seen_d, cfg_err_q, cfg_err_d;

  // Read-latency sideband pipeline
  logic [RD_LAT-1:0] pipe_vld_q, pipe_sof_q, pipe_eol_q, pipe_eof_q;

  // Output FIFO (first-word-fall-through with bypass when empty)
  logic [PW+2:0]  mem_q [FD];
  logic [PTW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d, inflight_q, inflight_d;

  // Start-time configuration check (multipliers live here, never in the issue path)
  logic [3:0]    step_eff;
  logic [31:0]   x_last, y_last;
  logic          cfg_ok;
  logic [AB-1:0] start_addr_c;
  logic [AW-1:0] row_inc_c;

  always_comb begin
    step_eff     = (step == 4'd0) ? 4'd1 : step;
    x_last       = 32'(roi_x0) + (32'(roi_w) - 32'd1) * 32'(step_eff);
    y_last       = 32'(roi_y0) + (32'(roi_h) - 32'd1) * 32'(step_eff);
    cfg_ok       = (roi_w != 16'd0) && (roi_h != 16'd0) &&
                   (x_last <= IN_W - 1) && (y_last <= IN_H - 1);
    start_addr_c = AB'(32'(roi_y0) * IN_W + 32'(roi_x0));
    row_inc_c    = AW'(32'(step_eff) * IN_W);
  end

  // Issue decision and per-pixel markers
  logic credit, issue, col_last, row_last, frame_last, reload;
  logic [AW-1:0] col_sum, row_sum;

  always_comb begin
    credit     = ((CW + 1)'(inflight_q) + (CW + 1)'(count_q)) < (CW + 1)'(FD);
    issue      = (state_q == StIssue) && credit;
    col_last   = (rx_q == w_q - 16'd1);
    row_last   = (ry_q == h_q - 16'd1);
    frame_last = col_last && row_last;
    reload     = cont_q && !(stop_seen_q || stop) && cfg_ok;
    col_sum    = {1'b0, addr_q} + AW'(step_q);
    row_sum    = {1'b0, row_base_q} + row_inc_q;
  end

  // FIFO datapath
  logic          fifo_empty, pipe_out, pop, push, rd_adv;
  logic [PW+2:0] head;

  always_comb begin
    fifo_empty = (count_q == '0);
    pipe_out   = pipe_vld_q[RD_LAT-1];
    head       = fifo_empty ? {pipe_eof_q[RD_LAT-1], pipe_eol_q[RD_LAT-1],
                               pipe_sof_q[RD_LAT-1], bram_dout}
                            : mem_q[rd_ptr_q];
    m_valid    = !fifo_empty || pipe_out;
    pop        = m_valid && m_ready;
    // A returning beat consumed straight off the bypass never gets stored.
    push       = pipe_out && !(fifo_empty && pop);
    rd_adv     = pop && !fifo_empty;
    count_d    = count_q + CW'(push) - CW'(rd_adv);
    inflight_d = inflight_q + CW'(issue) - CW'(pipe_out);
  end

  always_comb begin
    m_data     = m_valid ? head[PW-1:0] : '0;
    m_sof      = m_valid && head[PW];
    m_eol      = m_valid && head[PW+1];
    m_eof      = m_valid && head[PW+2];
    frame_done = pop && head[PW+2];
    bram_en    = issue;
    bram_addr  = issue ? addr_q : '0;
    busy       = (state_q != StIdle);
    cfg_err    = cfg_err_q;
  end

  // FSM next state and counter updates
  logic latch;

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    step_d      = step_q;
    row_inc_d   = row_inc_q;
    addr_d      = addr_q;
    row_base_d  = row_base_q;
    rx_d        = rx_q;
    ry_d        = ry_q;
    cont_d      = cont_q;
    stop_seen_d = stop_seen_q;
    cfg_err_d   = cfg_err_q;
    latch       = 1'b0;

    unique case (state_q)
      StIdle: begin
        stop_seen_d = 1'b0;
        if (start) begin
          if (cfg_ok) begin
            latch     = 1'b1;
            cont_d    = cont;
            cfg_err_d = 1'b0;
            state_d   = StIssue;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (stop) stop_seen_d = 1'b1;
        if (issue) begin
          if (frame_last) begin
            stop_seen_d = 1'b0;
            // Back-to-back frames: reload in the same cycle so no bubble appears.
            if (reload) latch = 1'b1;
            else        state_d = StDrain;
          end else if (col_last) begin
            rx_d       = 16'd0;
            ry_d       = ry_q + 16'd1;
            row_base_d = AB'(row_sum);
            addr_d     = AB'(row_sum);
          end else begin
            rx_d   = rx_q + 16'd1;
            addr_d = AB'(col_sum);
          end
        end
      end
      StDrain: begin
        if ((count_d == '0) && (inflight_d == '0)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (latch) begin
      w_d        = roi_w;
      h_d        = roi_h;
      step_d     = step_eff;
      row_inc_d  = row_inc_c;
      rx_d       = 16'd0;
      ry_d       = 16'd0;
      addr_d     = start_addr_c;
      row_base_d = start_addr_c;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= StIdle;
      w_q         <= '0;
      h_q         <= '0;
      step_q      <= '0;
      row_inc_q   <= '0;
      addr_q      <= '0;
      row_base_q  <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      cont_q      <= 1'b0;
      stop_seen_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_sof_q  <= '0;
      pipe_eol_q  <= '0;
      pipe_eof_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      step_q      <= step_d;
      row_inc_q   <= row_inc_d;
      addr_q      <= addr_d;
      row_base_q  <= row_base_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      cont_q      <= cont_d;
      stop_seen_q <= stop_seen_d;
      cfg_err_q   <= cfg_err_d;
      pipe_vld_q[0] <= issue;
      pipe_sof_q[0] <= (rx_q == 16'd0) && (ry_q == 16'd0);
      pipe_eol_q[0] <= col_last;
      pipe_eof_q[0] <= frame_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_sof_q[i] <= pipe_sof_q[i-1];
        pipe_eol_q[i] <= pipe_eol_q[i-1];
        pipe_eof_q[i] <= pipe_eof_q[i-1];
      end
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_adv) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {pipe_eof_q[RD_LAT-1], pipe_eol_q[RD_LAT-1],
                          pipe_sof_q[RD_LAT-1], bram_dout};
    end
  end

endmodule

// File: tb/tb_bram_frame_streamer.sv
// Testbench for bram_frame_streamer on an 8x4 stored frame whose BRAM holds each pixel's
// own address. Stimulus pushes the expected beat sequence of each frame into a queue; a
// negedge monitor pops and compares on every transfer, and also watches stall stability
// and the bound on outstanding reads.
`timescale 1ns/1ps
module tb_bram_frame_streamer;
  localparam int IN_W   = 8;
  localparam int IN_H   = 4;
  localparam int AB     = 5;
  localparam int PW     = 8;
  localparam int RD_LAT = 3;
  localparam int FD     = 8;

  logic          clk = 1'b0;
  logic          srst, start, stop, cont, m_ready;
  logic [15:0]   roi_x0, roi_y0, roi_w, roi_h;
  logic [3:0]    step;
  logic [AB-1:0] bram_addr;
  logic          bram_en;
  logic [PW-1:0] bram_dout;
  logic          m_valid, m_sof, m_eol, m_eof, busy, frame_done, cfg_err;
  logic [PW-1:0] m_data;

  bram_frame_streamer #(
    .IN_W(IN_W), .IN_H(IN_H), .AB(AB), .PW(PW), .RD_LAT(RD_LAT), .FD(FD)
  ) dut (
    .clk(clk), .srst(srst), .start(start), .stop(stop), .cont(cont),
    .roi_x0(roi_x0), .roi_y0(roi_y0), .roi_w(roi_w), .roi_h(roi_h), .step(step),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_dout(bram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: content equals address, RD_LAT-stage read pipeline
  logic [PW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= bram_en ? PW'(bram_addr) : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_dout = rd_pipe[RD_LAT-1];

  typedef struct packed {
    logic [PW-1:0] data;
    logic sof, eol, eof;
  } beat_t;

  beat_t sb[$];
  int cmp_cnt = 0, err_cnt = 0;
  int ready_pct = 100;
  int en_total = 0, xfer_total = 0, fd_cnt = 0, issued = 0, xfers = 0;
  int start_cyc = 0, first_valid_cyc = 0, first_xfer_cyc = -1, last_xfer_cyc = 0;
  bit first_seen = 1'b1, prev_stall = 1'b0;
  logic [PW+2:0] prev_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: row-major walk of the decimated ROI
  task automatic push_frame(input int x0, input int y0, input int w, input int h, input int s);
    int se;
    se = (s == 0) ? 1 : s;
    for (int ry = 0; ry < h; ry++) begin
      for (int rx = 0; rx < w; rx++) begin
        beat_t b;
        int a;
        a = (y0 + ry * se) * IN_W + x0 + rx * se;
        b.data = PW'(a);
        b.sof  = (rx == 0) && (ry == 0);
        b.eol  = (rx == w - 1);
        b.eof  = (rx == w - 1) && (ry == h - 1);
        sb.push_back(b);
      end
    end
  endtask

  task automatic set_cfg(input int x0, input int y0, input int w, input int h, input int s);
    roi_x0 = 16'(x0);
    roi_y0 = 16'(y0);
    roi_w  = 16'(w);
    roi_h  = 16'(h);
    step   = 4'(s);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start          = 1'b1;
    start_cyc      = cyc;
    first_seen     = 1'b0;
    first_xfer_cyc = -1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check({name, "_timeout"}, 64'(sb.size()), 64'(0));
      sb.delete();
    end
    @(negedge clk);
    check({name, "_busy_low"}, 64'({busy, m_valid}), 64'(0));
  endtask

  task automatic wait_xfers(input int target);
    int n;
    n = 0;
    while (xfer_total < target && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_xfers_timeout", 64'(xfer_total >= target), 64'(1));
  endtask

  // Downstream ready driver
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor / scoreboard
  initial begin
    beat_t exp_b;
    forever begin
      @(negedge clk);
      if (bram_en) en_total++;
      if (srst) begin
        prev_stall = 1'b0;
        issued     = 0;
        xfers      = 0;
      end else begin
        if (bram_en) issued++;
        if (busy) check("outstanding_le_fd", 64'((issued - xfers) <= FD), 64'(1));
        if (prev_stall)
          check("stall_hold", 64'({m_valid, m_data, m_sof, m_eol, m_eof}),
                64'({1'b1, prev_beat}));
        if (!first_seen && m_valid) begin
          first_seen      = 1'b1;
          first_valid_cyc = cyc;
        end
        if (m_valid && m_ready) begin
          xfers++;
          xfer_total++;
          if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
          last_xfer_cyc = cyc;
          if (sb.size() == 0) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL unexpected_beat: got data %0h, expected no beat", m_data);
          end else begin
            exp_b = sb.pop_front();
            check("beat{data,sof,eol,eof,done}",
                  64'({m_data, m_sof, m_eol, m_eof, frame_done}), 64'({exp_b, exp_b.eof}));
          end
        end
        if (frame_done) fd_cnt++;
        prev_stall = m_valid && !m_ready;
        prev_beat  = {m_data, m_sof, m_eol, m_eof};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, en0, s, se, w, h, x0, y0;
    srst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cont = 1'b0;
    set_cfg(0, 0, 8, 4, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stream", 64'({m_valid, m_data, m_sof, m_eol, m_eof}), 64'(0));
    check("rst_bram", 64'({bram_en, bram_addr}), 64'(0));
    check("rst_status", 64'({busy, frame_done, cfg_err}), 64'(0));
    #1;
    srst = 1'b0;

    // Full frame, no backpressure: latency, gapless 32 beats, one frame_done
    ready_pct = 100;
    push_frame(0, 0, 8, 4, 1);
    fd0 = fd_cnt;
    pulse_start();
    wait_idle("full");
    check("first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'(RD_LAT + 1));
    check("full_span", 64'(last_xfer_cyc - first_xfer_cyc), 64'(31));
    check("full_frame_done", 64'(fd_cnt - fd0), 64'(1));

    // Decimated ROI: addresses 9,11,13,25,27,29
    set_cfg(1, 1, 3, 2, 2);
    push_frame(1, 1, 3, 2, 2);
    pulse_start();
    wait_idle("decim");

    // Backpressure at 30% ready
    ready_pct = 30;
    set_cfg(0, 0, 8, 4, 1);
    push_frame(0, 0, 8, 4, 1);
    fd0 = fd_cnt;
    pulse_start();
    wait_idle("bp");
    check("bp_frame_done", 64'(fd_cnt - fd0), 64'(1));

    // Random legal ROIs under random backpressure
    for (int it = 0; it < 8; it++) begin
      s  = $urandom_range(0, 3);
      se = (s == 0) ? 1 : s;
      w  = $urandom_range(1, (IN_W - 1) / se + 1);
      h  = $urandom_range(1, (IN_H - 1) / se + 1);
      x0 = $urandom_range(0, IN_W - 1 - (w - 1) * se);
      y0 = $urandom_range(0, IN_H - 1 - (h - 1) * se);
      case ($urandom_range(0, 2))
        0:       ready_pct = 30;
        1:       ready_pct = 70;
        default: ready_pct = 100;
      endcase
      set_cfg(x0, y0, w, h, s);
      push_frame(x0, y0, w, h, s);
      fd0 = fd_cnt;
      pulse_start();
      wait_idle("rand");
      check("rand_frame_done", 64'(fd_cnt - fd0), 64'(1));
    end

    // Single-pixel frame
    ready_pct = 100;
    set_cfg(5, 2, 1, 1, 1);
    push_frame(5, 2, 1, 1, 1);
    pulse_start();
    wait_idle("single");

    // Bad configs are rejected without any read
    set_cfg(0, 0, 0, 4, 1);
    en0 = en_total;
    pulse_start();
    @(negedge clk);
    check("bad_w0_cfg_err_busy", 64'({cfg_err, busy}), 64'(2'b10));
    set_cfg(6, 0, 3, 1, 1);
    pulse_start();
    repeat (5) @(negedge clk);
    check("bad_x_cfg_err_busy", 64'({cfg_err, busy}), 64'(2'b10));
    check("bad_no_bram_en", 64'(en_total - en0), 64'(0));
    set_cfg(0, 0, 2, 1, 1);
    push_frame(0, 0, 2, 1, 1);
    pulse_start();
    @(negedge clk);
    check("cfg_err_cleared", 64'(cfg_err), 64'(0));
    wait_idle("after_bad");

    // Continuous mode, stop mid frame 2: exactly two gapless frames
    set_cfg(0, 0, 8, 4, 1);
    push_frame(0, 0, 8, 4, 1);
    push_frame(0, 0, 8, 4, 1);
    fd0 = fd_cnt;
    cont = 1'b1;
    pulse_start();
    cont = 1'b0;
    wait_xfers(xfer_total + 42);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    wait_idle("cont");
    check("cont_span", 64'(last_xfer_cyc - first_xfer_cyc), 64'(63));
    check("cont_frame_done", 64'(fd_cnt - fd0), 64'(2));
    en0 = en_total;
    repeat (20) @(negedge clk);
    check("cont_no_third_frame", 64'(en_total - en0), 64'(0));

    // Reset mid-frame, then replay from beat 0
    push_frame(0, 0, 8, 4, 1);
    pulse_start();
    wait_xfers(xfer_total + 10);
    srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_stream", 64'({m_valid, m_data, m_sof, m_eol, m_eof}), 64'(0));
    check("midrst_status", 64'({bram_en, bram_addr, busy, frame_done, cfg_err}), 64'(0));
    sb.delete();
    #1;
    srst = 1'b0;
    push_frame(0, 0, 8, 4, 1);
    fd0 = fd_cnt;
    pulse_start();
    wait_idle("replay");
    check("replay_frame_done", 64'(fd_cnt - fd0), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
